// File: rtl/reg_native_initiator_if.sv
// reg_native request/acknowledge bus between an initiator (master) and a responder (slave).
interface reg_native_initiator_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6
);
    logic                  req_vld;
    logic                  req_rdy;
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ack_vld;
    logic                  ack_rdy;

    modport master (
        output req_vld, wr_en, rd_en, addr, wr_data, ack_rdy,
        input  req_rdy, rd_data, ack_vld
    );

    modport slave (
        input  req_vld, wr_en, rd_en, addr, wr_data, ack_rdy,
        output req_rdy, rd_data, ack_vld
    );
endinterface

// File: rtl/reg_native_initiator.sv
// reg_native initiator: one command in flight, request -> acknowledge -> response.
// Optional request/acknowledge timeout enabled by defining REG_NATIVE_INIT_TIMEOUT_EN.
module reg_native_initiator #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned TO_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_vld,
    output logic                   cmd_rdy,
    input  logic                   cmd_wr,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0]  cmd_wdata,
    reg_native_initiator_if.master bus,
    output logic                   rsp_vld,
    input  logic                   rsp_rdy,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   rsp_err
);

    typedef enum logic [1:0] {StIdle, StReq, StWaitAck, StRsp} state_e;

    state_e                state;
    logic                  req_vld_q;
    logic                  wr_en_q;
    logic                  rd_en_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  rsp_vld_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

`ifdef REG_NATIVE_INIT_TIMEOUT_EN
    // Fires on the (2^TO_WIDTH-1)th cycle spent in REQ/WAIT_ACK.
    localparam logic [TO_WIDTH-1:0] ToLast = {{(TO_WIDTH-1){1'b1}}, 1'b0};

    logic [TO_WIDTH-1:0] to_cnt_q;
    logic                rsp_err_q;
    logic                to_expire;

    assign to_expire = (to_cnt_q == ToLast);
    assign rsp_err   = rsp_err_q;
`else
    logic unused_to_width;

    assign unused_to_width = (TO_WIDTH != 0);
    assign rsp_err         = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            req_vld_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef REG_NATIVE_INIT_TIMEOUT_EN
            to_cnt_q    <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
`ifdef REG_NATIVE_INIT_TIMEOUT_EN
            if (state == StReq || state == StWaitAck) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
`endif
            unique case (state)
                StIdle: begin
                    if (cmd_vld) begin
                        addr_q    <= cmd_addr;
                        wr_data_q <= cmd_wdata;
                        wr_en_q   <= cmd_wr;
                        rd_en_q   <= ~cmd_wr;
                        req_vld_q <= 1'b1;
                        state     <= StReq;
`ifdef REG_NATIVE_INIT_TIMEOUT_EN
                        to_cnt_q  <= '0;
`endif
                    end
                end
                StReq: begin
                    if (bus.req_rdy) begin
                        req_vld_q <= 1'b0;
                        state     <= StWaitAck;
                    end
`ifdef REG_NATIVE_INIT_TIMEOUT_EN
                    else if (to_expire) begin
                        req_vld_q   <= 1'b0;
                        wr_en_q     <= 1'b0;
                        rd_en_q     <= 1'b0;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_vld_q   <= 1'b1;
                        state       <= StRsp;
                    end
`endif
                end
                StWaitAck: begin
                    if (bus.ack_vld) begin
                        rsp_rdata_q <= rd_en_q ? bus.rd_data : '0;
                        rsp_vld_q   <= 1'b1;
                        wr_en_q     <= 1'b0;
                        rd_en_q     <= 1'b0;
                        state       <= StRsp;
`ifdef REG_NATIVE_INIT_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                    end
`ifdef REG_NATIVE_INIT_TIMEOUT_EN
                    else if (to_expire) begin
                        wr_en_q     <= 1'b0;
                        rd_en_q     <= 1'b0;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_vld_q   <= 1'b1;
                        state       <= StRsp;
                    end
`endif
                end
                StRsp: begin
                    if (rsp_rdy) begin
                        rsp_vld_q <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign cmd_rdy     = (state == StIdle) && !rst;
    assign bus.ack_rdy = (state == StWaitAck) && bus.ack_vld;
    assign bus.req_vld = req_vld_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.rd_en   = rd_en_q;
    assign bus.addr    = addr_q;
    assign bus.wr_data = wr_data_q;
    assign rsp_vld     = rsp_vld_q;
    assign rsp_rdata   = rsp_rdata_q;

endmodule
